// File: rtl/clk_path_pkg.sv
// Shared types and constants for the clock path selection controller.
package clk_path_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    ACK    = 3'd4
  } state_t;

  localparam logic [1:0] SEL_B       = 2'b00;
  localparam logic [1:0] SEL_A       = 2'b01;
  localparam logic [1:0] SEL_CROSS_A = 2'b10;
  localparam logic [1:0] SEL_A_BOTH  = 2'b11;

  localparam int CNT_W    = 8;
  localparam int SW_CNT_W = 16;

endpackage

// File: rtl/clk_path_rr_arb.sv
// Two-requester round-robin arbiter: on a tie, the requester not served last wins.
module clk_path_rr_arb (
  input  logic [1:0] req,        // bit 0 = A, bit 1 = B
  input  logic       last_grant, // 0 = A served last, 1 = B served last
  output logic       grant,
  output logic       grant_id    // 0 = A, 1 = B
);

  always_comb begin
    grant    = |req;
    grant_id = 1'b0;
    case (req)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/clock_path_sel_ctrl.sv
// Sequences path_sel changes: gate capture, drain, switch, settle, then acknowledge.
// Optional saturating switch counter enabled by the CLK_PATH_SWITCH_CNT_EN macro.
module clock_path_sel_ctrl
  import clk_path_pkg::*;
#(
  parameter int unsigned DRAIN_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter logic [1:0]  RST_SEL    = SEL_B
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       req_a,
  input  logic [1:0] sel_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [1:0] sel_b,
  output logic       ack_b,
  output logic [1:0] path_sel,
  output logic       cap_en,
  output logic       busy,
  output logic       last_grant
`ifdef CLK_PATH_SWITCH_CNT_EN
  ,
  input  logic                cnt_clr,
  output logic [SW_CNT_W-1:0] switch_cnt
`endif
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             gid_q, gid_d;
  logic [1:0]       path_sel_q, path_sel_d;
  logic             cap_en_q, cap_en_d;
  logic             busy_q, busy_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             last_grant_q, last_grant_d;

  logic       grant, grant_id;
  logic [1:0] grant_sel;

  // A requester acked last cycle may still hold req; mask it so it is not re-served.
  clk_path_rr_arb u_arb (
    .req        ({req_b & ~ack_b_q, req_a & ~ack_a_q}),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign grant_sel = grant_id ? sel_b : sel_a;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    gid_d        = gid_q;
    path_sel_d   = path_sel_q;
    cap_en_d     = cap_en_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          sel_d        = grant_sel;
          gid_d        = grant_id;
          last_grant_d = grant_id;
          if (grant_sel == path_sel_q) begin
            state_d = ACK;
          end else begin
            cnt_d    = DRAIN_LOAD;
            cap_en_d = 1'b0;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = SWITCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SWITCH: begin
        path_sel_d = sel_q;
        cnt_d      = SETTLE_LOAD;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          cap_en_d = 1'b1;
          state_d  = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        ack_a_d = ~gid_q;
        ack_b_d = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= RST_SEL;
      gid_q        <= 1'b0;
      path_sel_q   <= RST_SEL;
      cap_en_q     <= 1'b1;
      busy_q       <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      gid_q        <= gid_d;
      path_sel_q   <= path_sel_d;
      cap_en_q     <= cap_en_d;
      busy_q       <= busy_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign path_sel   = path_sel_q;
  assign cap_en     = cap_en_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;

`ifdef CLK_PATH_SWITCH_CNT_EN
  logic [SW_CNT_W-1:0] switch_cnt_q, switch_cnt_d;

  // SWITCH is only reached when path_sel actually changes; clear beats increment.
  always_comb begin
    switch_cnt_d = switch_cnt_q;
    if (cnt_clr)                                           switch_cnt_d = '0;
    else if (state_q == SWITCH && switch_cnt_q != '1)      switch_cnt_d = switch_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) switch_cnt_q <= '0;
    else     switch_cnt_q <= switch_cnt_d;
  end

  assign switch_cnt = switch_cnt_q;
`endif

endmodule

// File: tb/tb_clock_path_sel_ctrl.sv
// Self-checking bench for clock_path_sel_ctrl against a cycle-timeline reference model.
// Counter checks are built when CLK_PATH_SWITCH_CNT_EN is defined.
module tb_clock_path_sel_ctrl;

  localparam int         D    = 4;
  localparam int         S    = 8;
  localparam logic [1:0] RSEL = 2'b00;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [1:0] sel_a = 2'b00, sel_b = 2'b00;
  logic       ack_a, ack_b, cap_en, busy, last_grant;
  logic [1:0] path_sel;

  int checks = 0;
  int failures = 0;

  // Reference state: current selection and who was served last.
  logic [1:0] mdl_sel = RSEL;
  bit         mdl_lg  = 1'b1;

`ifdef CLK_PATH_SWITCH_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] switch_cnt;
`endif

  clock_path_sel_ctrl #(.DRAIN_CYC(D), .SETTLE_CYC(S), .RST_SEL(RSEL)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .req_a      (req_a),
    .sel_a      (sel_a),
    .ack_a      (ack_a),
    .req_b      (req_b),
    .sel_b      (sel_b),
    .ack_b      (ack_b),
    .path_sel   (path_sel),
    .cap_en     (cap_en),
    .busy       (busy),
    .last_grant (last_grant)
`ifdef CLK_PATH_SWITCH_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .switch_cnt (switch_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  initial assert (D >= 1 && D <= 255 && S >= 1 && S <= 255)
    else $error("timing parameter out of range 1..255");

  task automatic do_reset();
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
`ifdef CLK_PATH_SWITCH_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(negedge clk_in);
    rst     = 1'b0;
    mdl_sel = RSEL;
    mdl_lg  = 1'b1;
  endtask

  task automatic check_idle(input int cycles, input string tag);
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk_in);
      checks++;
      if ({path_sel, cap_en, busy, ack_a, ack_b} !== {mdl_sel, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s cyc=%0d {sel,cap,busy,ack_a,ack_b} got=%b exp=%b", tag, k,
                 {path_sel, cap_en, busy, ack_a, ack_b}, {mdl_sel, 1'b1, 1'b0, 1'b0, 1'b0});
      end
    end
  endtask

  // Drives one request pattern and checks every cycle against a timeline derived
  // from the rules: grant at cycle g, capture gated for D+1+S cycles on a change,
  // new selection visible D+2 cycles after grant, ack at g+D+S+3 (or g+2 if unchanged).
  task automatic run_txn(input bit ra, input logic [1:0] sa, input bit rb,
                         input logic [1:0] sb, input string tag);
    int         n, last;
    int         g[2], ta[2];
    bit         id[2], chg[2];
    logic [1:0] s[2];
    logic [1:0] init_sel, e_sel;
    bit         drop_a, drop_b, e_ack_a, e_ack_b, e_cap, e_busy;

    n = 0;
    if (ra && rb) begin
      id[0] = ~mdl_lg;
      id[1] = mdl_lg;
      n = 2;
    end else if (ra) begin
      id[0] = 1'b0;
      n = 1;
    end else if (rb) begin
      id[0] = 1'b1;
      n = 1;
    end
    init_sel = mdl_sel;
    g[0] = 0;
    for (int i = 0; i < n; i++) begin
      s[i]   = id[i] ? sb : sa;
      chg[i] = (s[i] != mdl_sel);
      if (i > 0) g[i] = ta[i-1];
      ta[i]  = g[i] + (chg[i] ? D + S + 3 : 2);
      mdl_sel = s[i];
      mdl_lg  = id[i];
    end
    last = (n > 0) ? ta[n-1] + 2 : 4;

    req_a = ra; sel_a = sa;
    req_b = rb; sel_b = sb;
    drop_a = 1'b0;
    drop_b = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk_in);
      if (drop_a) req_a = 1'b0;
      if (drop_b) req_b = 1'b0;
      e_ack_a = 1'b0; e_ack_b = 1'b0; e_cap = 1'b1; e_busy = 1'b0; e_sel = init_sel;
      for (int i = 0; i < n; i++) begin
        if (k == ta[i]) begin
          if (id[i]) e_ack_b = 1'b1;
          else       e_ack_a = 1'b1;
        end
        if (chg[i] && k > g[i] && k <= g[i] + D + S + 1) e_cap = 1'b0;
        if (k > g[i] && k < ta[i]) e_busy = 1'b1;
        if (chg[i] && k >= g[i] + D + 2) e_sel = s[i];
      end
      checks++;
      if ({ack_a, ack_b, cap_en, busy, path_sel} !== {e_ack_a, e_ack_b, e_cap, e_busy, e_sel}) begin
        failures++;
        $display("FAIL %s cyc=%0d {ack_a,ack_b,cap,busy,sel} got=%b exp=%b", tag, k,
                 {ack_a, ack_b, cap_en, busy, path_sel}, {e_ack_a, e_ack_b, e_cap, e_busy, e_sel});
      end
      // Requester releases req in the cycle after its ack.
      drop_a |= e_ack_a;
      drop_b |= e_ack_b;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    checks++;
    if (last_grant !== mdl_lg) begin
      failures++;
      $display("FAIL %s last_grant got=%b exp=%b", tag, last_grant, mdl_lg);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (last_grant !== 1'b1) begin
      failures++;
      $display("FAIL reset_last_grant got=%b exp=1", last_grant);
    end
    check_idle(20, "reset_idle");
  endtask

  task automatic test_single();
    do_reset();
    run_txn(1'b1, 2'b01, 1'b0, 2'b00, "single_a");
  endtask

  task automatic test_simultaneous();
    do_reset();
    run_txn(1'b1, 2'b10, 1'b1, 2'b11, "simultaneous");
    checks++;
    if (path_sel !== 2'b11 || last_grant !== 1'b1) begin
      failures++;
      $display("FAIL simultaneous_final {sel,last_grant} got=%b exp=111", {path_sel, last_grant});
    end
  endtask

  task automatic test_same_value();
    run_txn(1'b1, 2'b01, 1'b0, 2'b00, "same_setup");
    run_txn(1'b0, 2'b00, 1'b1, 2'b01, "same_value_b");
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_a = 1'b1;
    sel_a = 2'b11;
    repeat (9) @(negedge clk_in);
    checks++;
    if ({busy, cap_en, path_sel} !== {1'b1, 1'b0, 2'b11}) begin
      failures++;
      $display("FAIL mid_before_rst {busy,cap,sel} got=%b exp=1011", {busy, cap_en, path_sel});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({path_sel, cap_en, busy, ack_a, ack_b} !== {RSEL, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset {sel,cap,busy,ack_a,ack_b} got=%b exp=%b",
               {path_sel, cap_en, busy, ack_a, ack_b}, {RSEL, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk_in);
    req_a = 1'b0;
    @(negedge clk_in);
    rst     = 1'b0;
    mdl_sel = RSEL;
    mdl_lg  = 1'b1;
    check_idle(20, "mid_after_rst");
  endtask

  task automatic test_random();
    int         mode;
    logic [1:0] sa, sb;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 2));
      sa   = 2'($urandom_range(0, 3));
      sb   = 2'($urandom_range(0, 3));
      run_txn(mode != 1, sa, mode != 0, sb, "random");
    end
  endtask

`ifdef CLK_PATH_SWITCH_CNT_EN
  task automatic check_cnt(input logic [15:0] exp, input string tag);
    checks++;
    if (switch_cnt !== exp) begin
      failures++;
      $display("FAIL %s switch_cnt got=%h exp=%h", tag, switch_cnt, exp);
    end
  endtask

  task automatic test_counter();
    do_reset();
    check_cnt(16'h0000, "cnt_reset");
    run_txn(1'b1, 2'b01, 1'b0, 2'b00, "cnt_change");
    check_cnt(16'h0001, "cnt_one");
    run_txn(1'b0, 2'b00, 1'b1, 2'b01, "cnt_same");
    check_cnt(16'h0001, "cnt_same_hold");
    // Clear asserted while the FSM sits in SWITCH (cycle D+1 after grant).
    req_a = 1'b1;
    sel_a = 2'b10;
    for (int k = 1; k <= D + S + 5; k++) begin
      @(negedge clk_in);
      cnt_clr = (k == D + 1);
      if (k == D + S + 4) req_a = 1'b0;
    end
    cnt_clr = 1'b0;
    mdl_sel = 2'b10;
    mdl_lg  = 1'b0;
    check_cnt(16'h0000, "cnt_clr_wins");
    force dut.switch_cnt_q = 16'hFFFE;
    @(negedge clk_in);
    release dut.switch_cnt_q;
    run_txn(1'b1, 2'b11, 1'b0, 2'b00, "cnt_to_max");
    check_cnt(16'hFFFF, "cnt_max");
    run_txn(1'b0, 2'b00, 1'b1, 2'b00, "cnt_sat");
    check_cnt(16'hFFFF, "cnt_saturated");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_same_value();
    test_reset_mid();
    test_random();
`ifdef CLK_PATH_SWITCH_CNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
